wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between three writeback requesters: ALU result, memory load return, and link address (PC+4 for jal-type instructions).
- Grants one requester per cycle and registers its destination and data.
- Drives the 2-bit MemtoReg select (00 ALU, 01 MEM, 10 PC_4) that steers the downstream writeback mux.
- Sits between the execute/memory stages and the register file.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a requester may be valid but ungranted before it is forced to top priority (1..15).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- mem_valid  in  1  load result available
- mem_rd  in  5  load destination register
- mem_data  in  32  load data
- mem_ready  out  1  load result accepted this cycle
- alu_valid  in  1  ALU result available
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- link_valid  in  1  link write available
- link_rd  in  5  link destination register
- link_pc4  in  32  return address
- link_ready  out  1  link write accepted this cycle
- MemtoReg  out  2  writeback mux select, registered
- reg_write  out  1  register-file write enable, registered
- write_reg  out  5  register-file write address, registered
- data_from_mem  out  32  registered load data to mux
- alu_result  out  32  registered ALU data to mux
- PC_4  out  32  registered link data to mux
- conflict_cnt  out  CNT_W  saturating count of cycles with two or more requesters valid

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: MemtoReg=00, reg_write=0, write_reg=0, data_from_mem/alu_result/PC_4=0, conflict_cnt=0, all age counters=0.
- During reset, all *_ready outputs=0.
- Handshake: a transfer occurs when valid&ready in the same cycle.
  - ready is combinational from valid and arbitration state.
  - At most one ready is high per cycle.
  - ready is never high without its own valid.
  - A requester must hold valid, rd and data stable until its transfer.
- Latency: a transfer in cycle N produces in cycle N+1:
  - reg_write=1 (unless rd=0),
  - write_reg=rd,
  - MemtoReg set to the source code,
  - the matching data output loaded.
  - The other two data outputs hold their previous values.
- No transfer in cycle N: reg_write=0 in N+1; MemtoReg and data outputs hold their previous values.
- rd=0: the transfer completes (ready=1) but reg_write=0 in N+1. write_reg and MemtoReg still update.
- Base priority: MEM > LINK > ALU.
- Aging, one 4-bit counter per requester:
  - Increments when the requester is valid and not granted.
  - Clears when it is granted or its valid is low.
  - A counter reaching STARVE_LIMIT marks that requester starved.
- Starved requesters beat all non-starved ones. Among several starved requesters, base priority applies.
- Counters saturate at 15.
- conflict_cnt: increments on every cycle with two or more valid inputs; saturates at all-ones; cleared only by reset.
- Reset mid-operation: a transfer presented in the reset cycle is not accepted (ready=0) and produces no write. All state clears.

Test Plan:
- Reset: hold reset 2 cycles with all valids=1 -> all ready=0, reg_write=0, MemtoReg=00, conflict_cnt=0; first cycle after reset: mem_ready=1.
- Single source: alu_valid=1, alu_rd=5, alu_data=0x0000_1234 for one cycle -> alu_ready=1 that cycle; next cycle reg_write=1, write_reg=5, MemtoReg=00, alu_result=0x0000_1234.
- Priority: all three valid at once (mem_rd=3/0xAAAA_0000, link_rd=31/0x0040_0008, alu_rd=7/0x11) -> grant order MEM, LINK, ALU on consecutive cycles; MemtoReg sequence 01, 10, 00; conflict_cnt=2.
- Starvation: mem_valid held high continuously with fresh rd each cycle, alu_valid high, STARVE_LIMIT=4 -> ALU ungranted 4 cycles, granted on the 5th (alu_ready=1, mem_ready=0), MEM resumes the next cycle.
- Zero register: link_valid=1, link_rd=0, link_pc4=0x100 -> link_ready=1; next cycle reg_write=0, MemtoReg=10, PC_4=0x100.
- Mid-operation reset: assert reset in the same cycle as mem_valid=1 -> mem_ready=0; next cycle reg_write=0 and all outputs at reset values.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between three writeback
//   requesters (load return, link address, ALU result).  One requester is
//   granted per cycle.  Its destination and data are registered, along with
//   the MemtoReg select that steers the downstream writeback mux.
//
//   Base priority is MEM > LINK > ALU.  A per-requester age counter tracks how
//   long a valid request has gone ungranted.  Once the counter reaches
//   STARVE_LIMIT, that requester outranks every non-starved requester.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   mem_valid/rd/data, mem_ready    load return request / accept
//   alu_valid/rd/data, alu_ready    ALU result request / accept
//   link_valid/rd/pc4, link_ready   link (PC+4) request / accept
//   MemtoReg                        registered mux select (00 ALU, 01 MEM, 10 PC_4)
//   reg_write, write_reg            registered write enable / address
//   data_from_mem, alu_result, PC_4 registered per-source data to the mux
//   conflict_cnt                    saturating count of cycles with >=2 valids
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      mem_data,
  output logic             mem_ready,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  output logic             alu_ready,
  input  logic             link_valid,
  input  logic [4:0]       link_rd,
  input  logic [31:0]      link_pc4,
  output logic             link_ready,
  output logic [1:0]       MemtoReg,
  output logic             reg_write,
  output logic [4:0]       write_reg,
  output logic [31:0]      data_from_mem,
  output logic [31:0]      alu_result,
  output logic [31:0]      PC_4,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  logic [3:0] age_mem, age_link, age_alu;
  logic       starve_mem, starve_link, starve_alu;
  logic       gnt_mem, gnt_link, gnt_alu;
  logic       conflict;

  // A requester only counts as starved while it is still asking.
  assign starve_mem  = mem_valid  && (age_mem  >= LIMIT);
  assign starve_link = link_valid && (age_link >= LIMIT);
  assign starve_alu  = alu_valid  && (age_alu  >= LIMIT);

  assign conflict = (mem_valid && link_valid) || (mem_valid && alu_valid) ||
                    (link_valid && alu_valid);

  // Starved requesters are considered first, in base order; then everyone.
  always_comb begin
    gnt_mem  = 1'b0;
    gnt_link = 1'b0;
    gnt_alu  = 1'b0;
    if (!reset) begin
      if (starve_mem)       gnt_mem  = 1'b1;
      else if (starve_link) gnt_link = 1'b1;
      else if (starve_alu)  gnt_alu  = 1'b1;
      else if (mem_valid)   gnt_mem  = 1'b1;
      else if (link_valid)  gnt_link = 1'b1;
      else if (alu_valid)   gnt_alu  = 1'b1;
    end
  end

  assign mem_ready  = gnt_mem;
  assign link_ready = gnt_link;
  assign alu_ready  = gnt_alu;

  function automatic logic [3:0] next_age(input logic [3:0] age,
                                          input logic valid,
                                          input logic gnt);
    if (!valid || gnt)      return 4'd0;
    else if (age == 4'hF)   return age;
    else                    return age + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      MemtoReg      <= SEL_ALU;
      reg_write     <= 1'b0;
      write_reg     <= 5'd0;
      data_from_mem <= 32'd0;
      alu_result    <= 32'd0;
      PC_4          <= 32'd0;
      conflict_cnt  <= '0;
      age_mem       <= 4'd0;
      age_link      <= 4'd0;
      age_alu       <= 4'd0;
    end else begin
      reg_write <= 1'b0;
      // x0 writes are accepted but suppressed at the register file.
      if (gnt_mem) begin
        reg_write     <= (mem_rd != 5'd0);
        write_reg     <= mem_rd;
        MemtoReg      <= SEL_MEM;
        data_from_mem <= mem_data;
      end else if (gnt_link) begin
        reg_write <= (link_rd != 5'd0);
        write_reg <= link_rd;
        MemtoReg  <= SEL_PC4;
        PC_4      <= link_pc4;
      end else if (gnt_alu) begin
        reg_write  <= (alu_rd != 5'd0);
        write_reg  <= alu_rd;
        MemtoReg   <= SEL_ALU;
        alu_result <= alu_data;
      end

      age_mem  <= next_age(age_mem,  mem_valid,  gnt_mem);
      age_link <= next_age(age_link, link_valid, gnt_link);
      age_alu  <= next_age(age_alu,  alu_valid,  gnt_alu);

      if (conflict && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_valid, alu_valid, link_valid;
  logic [4:0]       mem_rd, alu_rd, link_rd;
  logic [31:0]      mem_data, alu_data, link_pc4;
  logic             mem_ready, alu_ready, link_ready;
  logic [1:0]       MemtoReg;
  logic             reg_write;
  logic [4:0]       write_reg;
  logic [31:0]      data_from_mem, alu_result, PC_4;
  logic [CNT_W-1:0] conflict_cnt;

  int tests  = 0;
  int failed = 0;

  wb_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .link_valid(link_valid), .link_rd(link_rd), .link_pc4(link_pc4), .link_ready(link_ready),
    .MemtoReg(MemtoReg), .reg_write(reg_write), .write_reg(write_reg),
    .data_from_mem(data_from_mem), .alu_result(alu_result), .PC_4(PC_4),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    reset = rst;
    mem_valid = mv;  mem_rd = mrd;  mem_data = md;
    link_valid = lv; link_rd = lrd; link_pc4 = ld;
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
  endtask

  // Ready vector packed as {mem, link, alu}; sampled on the falling edge.
  task automatic check_ready(input string name, input logic [2:0] exp);
    @(negedge clk);
    chk(name, {29'd0, mem_ready, link_ready, alu_ready}, {29'd0, exp});
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sel_data(input logic [1:0] m2r);
    case (m2r)
      2'b01:   return data_from_mem;
      2'b10:   return PC_4;
      default: return alu_result;
    endcase
  endfunction

  typedef struct {
    logic        rst;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic [2:0]  rdy;
    logic        rw;  logic [4:0] wr;  logic [1:0] m2r;
    logic [31:0] dat; int cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: request sources 0=MEM, 1=LINK, 2=ALU in priority order.
  int   m_age[3];
  int   m_cnt;
  bit   m_rw;
  int   m_wr, m_m2r;
  int   m_dat[3];

  function automatic int pick(input bit v[3], input int a[3]);
    for (int s = 0; s < 3; s++) if (v[s] && a[s] >= STARVE_LIMIT) return s;
    for (int s = 0; s < 3; s++) if (v[s]) return s;
    return -1;
  endfunction

  initial begin
    drive(1, 0,0,0, 0,0,0, 0,0,0);
    //         rst mv mrd md            lv lrd ld            av ard ad          rdy     rw wr  m2r  dat           cnt
    vecs.push_back('{1, 1, 3, 32'hAAAA_0000, 1, 31, 32'h0040_0008, 1, 7, 32'h11, 3'b000, 0, 0,  2'b00, 32'h0,        0});
    vecs.push_back('{1, 1, 3, 32'hAAAA_0000, 1, 31, 32'h0040_0008, 1, 7, 32'h11, 3'b000, 0, 0,  2'b00, 32'h0,        0});
    vecs.push_back('{0, 1, 3, 32'hAAAA_0000, 1, 31, 32'h0040_0008, 1, 7, 32'h11, 3'b100, 1, 3,  2'b01, 32'hAAAA_0000, 1});
    vecs.push_back('{0, 0, 0, 32'h0,         1, 31, 32'h0040_0008, 1, 7, 32'h11, 3'b010, 1, 31, 2'b10, 32'h0040_0008, 2});
    vecs.push_back('{0, 0, 0, 32'h0,         0, 0,  32'h0,         1, 7, 32'h11, 3'b001, 1, 7,  2'b00, 32'h11,       2});
    vecs.push_back('{0, 0, 0, 32'h0,         0, 0,  32'h0,         0, 0, 32'h0,  3'b000, 0, 7,  2'b00, 32'h11,       2});
    vecs.push_back('{0, 0, 0, 32'h0,         0, 0,  32'h0,         1, 5, 32'h1234, 3'b001, 1, 5, 2'b00, 32'h1234,    2});
    vecs.push_back('{0, 0, 0, 32'h0,         1, 0,  32'h100,       0, 0, 32'h0,  3'b010, 0, 0,  2'b10, 32'h100,      2});
    vecs.push_back('{1, 1, 9, 32'hDEAD_BEEF, 0, 0,  32'h0,         0, 0, 32'h0,  3'b000, 0, 0,  2'b00, 32'h0,        0});
    vecs.push_back('{0, 1, 9, 32'hDEAD_BEEF, 0, 0,  32'h0,         0, 0, 32'h0,  3'b100, 1, 9,  2'b01, 32'hDEAD_BEEF, 0});

    edge_step();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].mv, vecs[i].mrd, vecs[i].md,
            vecs[i].lv, vecs[i].lrd, vecs[i].ld, vecs[i].av, vecs[i].ard, vecs[i].ad);
      check_ready($sformatf("vec%0d ready", i), vecs[i].rdy);
      edge_step();
      chk($sformatf("vec%0d reg_write", i), {31'd0, reg_write}, {31'd0, vecs[i].rw});
      chk($sformatf("vec%0d write_reg", i), {27'd0, write_reg}, {27'd0, vecs[i].wr});
      chk($sformatf("vec%0d MemtoReg", i),  {30'd0, MemtoReg},  {30'd0, vecs[i].m2r});
      chk($sformatf("vec%0d data", i),      sel_data(MemtoReg), vecs[i].dat);
      chk($sformatf("vec%0d conflict_cnt", i), {16'd0, conflict_cnt}, vecs[i].cnt);
      if (vecs[i].rst) begin
        chk($sformatf("vec%0d rst data_from_mem", i), data_from_mem, 32'h0);
        chk($sformatf("vec%0d rst PC_4", i), PC_4, 32'h0);
      end
    end

    // Starvation: MEM streams continuously, ALU waits four grants then wins.
    for (int i = 0; i < 6; i++) begin
      logic [4:0] mrd;
      mrd = 5'(10 + ((i < 5) ? i : 4));
      drive(0, 1, mrd, 32'h100 + i, 0, 0, 0, (i < 5), 12, 32'h55);
      check_ready($sformatf("starve%0d ready", i),
                  (i == 4) ? 3'b001 : 3'b100);
      edge_step();
      if (i == 4) begin
        chk("starve alu MemtoReg",  {30'd0, MemtoReg}, 32'd0);
        chk("starve alu write_reg", {27'd0, write_reg}, 32'd12);
        chk("starve alu_result",    alu_result, 32'h55);
      end
      if (i == 5) begin
        chk("starve mem resume MemtoReg",  {30'd0, MemtoReg}, 32'd1);
        chk("starve mem resume write_reg", {27'd0, write_reg}, 32'd14);
      end
    end

    // Randomized run against the reference model, starting from reset.
    begin
      bit          pend[3];
      logic [4:0]  rrd[3];
      logic [31:0] rdat[3];
      bit          rst;
      int          win;
      int          nv;
      pend = '{0, 0, 0};
      for (int s = 0; s < 3; s++) begin rrd[s] = 0; rdat[s] = 0; end
      for (int cyc = 0; cyc < 1500; cyc++) begin
        rst = (cyc == 0) || ($urandom_range(0, 40) == 0);
        for (int s = 0; s < 3; s++) begin
          if (!pend[s] && $urandom_range(0, 3) != 0) begin
            pend[s] = 1;
            rrd[s]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdat[s] = $urandom;
          end
        end
        drive(rst, pend[0], rrd[0], rdat[0], pend[1], rrd[1], rdat[1],
              pend[2], rrd[2], rdat[2]);
        win = rst ? -1 : pick(pend, m_age);
        check_ready($sformatf("rand%0d ready", cyc),
                    {win == 0, win == 1, win == 2});
        nv = int'(pend[0]) + int'(pend[1]) + int'(pend[2]);
        if (rst) begin
          m_age = '{0, 0, 0};
          m_cnt = 0; m_rw = 0; m_wr = 0; m_m2r = 0;
          m_dat = '{0, 0, 0};
        end else begin
          m_rw = 0;
          if (win >= 0) begin
            m_rw  = (rrd[win] != 0);
            m_wr  = rrd[win];
            m_m2r = (win == 0) ? 1 : (win == 1) ? 2 : 0;
            m_dat[win] = rdat[win];
          end
          for (int s = 0; s < 3; s++)
            m_age[s] = (pend[s] && s != win) ? ((m_age[s] < 15) ? m_age[s] + 1 : 15) : 0;
          if (nv >= 2 && m_cnt < 65535) m_cnt++;
          if (win >= 0) pend[win] = 0;
        end
        edge_step();
        chk($sformatf("rand%0d reg_write", cyc), {31'd0, reg_write}, {31'd0, m_rw});
        chk($sformatf("rand%0d write_reg", cyc), {27'd0, write_reg}, m_wr);
        chk($sformatf("rand%0d MemtoReg", cyc),  {30'd0, MemtoReg},  m_m2r);
        chk($sformatf("rand%0d data_from_mem", cyc), data_from_mem, m_dat[0]);
        chk($sformatf("rand%0d PC_4", cyc),          PC_4,          m_dat[1]);
        chk($sformatf("rand%0d alu_result", cyc),    alu_result,    m_dat[2]);
        chk($sformatf("rand%0d conflict_cnt", cyc),  {16'd0, conflict_cnt}, m_cnt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
